qracc_sram_arbiter: RTL and testbench

- Shares the single-port SRAM digital request interface (rq_wr_i/rq_valid_i/rq_ready_o/rd_valid_o/rd_data_o) between two requesters.
- Requester 0 is the host config/data bus path. Requester 1 is the internal weight/peripheral loader active during TRIGGER_LOADWEIGHTS_PERIPHS.
- Round-robin grant, request held stable while the SRAM stalls, in-order read-return routing via an ID FIFO.
- Sits between the controller-side masters and the SRAM macro wrapper (slave).

---
 rtl/qracc_pkg.sv | 14 +
 rtl/qracc_id_fifo.sv | 59 +++++
 rtl/qracc_sram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_qracc_sram_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types and constants for the QRAcc SRAM request arbiter.
// Holds the arbiter state encoding, requester ID type and default FIFO depth.
package qracc_pkg;

    typedef enum logic {
        ARB_IDLE_ARB,
        ARB_HOLD
    } qracc_sram_arb_state_t;

    typedef logic qracc_sram_req_id_t;

    parameter int sramArbMaxOutstanding = 4;

endpackage

// File: rtl/qracc_id_fifo.sv
// Small synchronous FIFO that records which requester owns each read in flight.
// Head is shown combinationally; push and pop in one cycle keep the count.
module qracc_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/qracc_sram_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port SRAM wrapper.
// Optional counters enabled with QRACC_SRAM_ARB_STATS_EN.
module qracc_sram_arbiter
    import qracc_pkg::*;
#(
    parameter int NUM_ROWS        = 128,
    parameter int NUM_COLS        = 32,
    parameter int MAX_OUTSTANDING = sramArbMaxOutstanding,
    localparam int AW             = $clog2(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                r0_valid_i,
    input  logic                r0_wr_i,
    input  logic [AW-1:0]       r0_addr_i,
    input  logic [NUM_COLS-1:0] r0_wdata_i,
    output logic                r0_ready_o,
    output logic                r0_rd_valid_o,
    output logic [NUM_COLS-1:0] r0_rd_data_o,
    input  logic                r1_valid_i,
    input  logic                r1_wr_i,
    input  logic [AW-1:0]       r1_addr_i,
    input  logic [NUM_COLS-1:0] r1_wdata_i,
    output logic                r1_ready_o,
    output logic                r1_rd_valid_o,
    output logic [NUM_COLS-1:0] r1_rd_data_o,
    output logic                rq_valid_o,
    output logic                rq_wr_o,
    output logic [AW-1:0]       addr_o,
    output logic [NUM_COLS-1:0] wr_data_o,
    input  logic                rq_ready_i,
    input  logic                rd_valid_i,
    input  logic [NUM_COLS-1:0] rd_data_i,
`ifdef QRACC_SRAM_ARB_STATS_EN
    output logic [31:0]         r0_grants_o,
    output logic [31:0]         r1_grants_o,
    output logic [31:0]         stall_cycles_o,
`endif
    output logic                err_o
);

    qracc_sram_arb_state_t state, state_nx;
    qracc_sram_req_id_t    rr_ptr, hold_id, gnt_id, fifo_head;

    logic [1:0]          elig;
    logic                gnt_vld;
    logic                hs;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [NUM_COLS-1:0] r0_last;
    logic [NUM_COLS-1:0] r1_last;

    // Reads are only eligible while a return slot is free; reset masks all.
    assign elig[0] = nrst & r0_valid_i & (r0_wr_i | ~fifo_full);
    assign elig[1] = nrst & r1_valid_i & (r1_wr_i | ~fifo_full);

    // Grant selection and next-state logic.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = rr_ptr;
        state_nx = state;
        unique case (state)
            ARB_IDLE_ARB: begin
                if (elig[rr_ptr]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = rr_ptr;
                end else if (elig[~rr_ptr]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ~rr_ptr;
                end
                if (gnt_vld && !rq_ready_i) state_nx = ARB_HOLD;
            end
            ARB_HOLD: begin
                gnt_vld = nrst;
                gnt_id  = hold_id;
                if (rq_ready_i) state_nx = ARB_IDLE_ARB;
            end
            default: state_nx = ARB_IDLE_ARB;
        endcase
    end

    // Steer the grantee's request onto the SRAM port.
    always_comb begin
        rq_valid_o = gnt_vld;
        rq_wr_o    = 1'b0;
        addr_o     = '0;
        wr_data_o  = '0;
        if (gnt_vld) begin
            if (gnt_id) begin
                rq_wr_o   = r1_wr_i;
                addr_o    = r1_addr_i;
                wr_data_o = r1_wdata_i;
            end else begin
                rq_wr_o   = r0_wr_i;
                addr_o    = r0_addr_i;
                wr_data_o = r0_wdata_i;
            end
        end
    end

    assign hs         = gnt_vld & rq_ready_i;
    assign r0_ready_o = hs & ~gnt_id;
    assign r1_ready_o = hs & gnt_id;
    assign push       = hs & ~rq_wr_o;
    assign pop        = nrst & rd_valid_i & ~fifo_empty;

    assign r0_rd_valid_o = pop & ~fifo_head;
    assign r1_rd_valid_o = pop & fifo_head;
    assign r0_rd_data_o  = r0_rd_valid_o ? rd_data_i : r0_last;
    assign r1_rd_data_o  = r1_rd_valid_o ? rd_data_i : r1_last;

    // State, round-robin pointer and held grantee.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ARB_IDLE_ARB;
            rr_ptr  <= 1'b0;
            hold_id <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ARB_IDLE_ARB && gnt_vld && !rq_ready_i)
                hold_id <= gnt_id;
            if (hs) rr_ptr <= ~gnt_id;
        end
    end

    // Last routed read data per requester and sticky return error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r0_last <= '0;
            r1_last <= '0;
            err_o   <= 1'b0;
        end else begin
            if (r0_rd_valid_o) r0_last <= rd_data_i;
            if (r1_rd_valid_o) r1_last <= rd_data_i;
            if (rd_valid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    qracc_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .din   (gnt_id),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef QRACC_SRAM_ARB_STATS_EN
    // Grant and stall counters, free-running with wrap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r0_grants_o    <= '0;
            r1_grants_o    <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (r0_ready_o) r0_grants_o <= r0_grants_o + 1'b1;
            if (r1_ready_o) r1_grants_o <= r1_grants_o + 1'b1;
            if (state == ARB_HOLD)
                stall_cycles_o <= stall_cycles_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed self-checking bench for qracc_sram_arbiter.
// Covers round-robin, stall hold, return routing, FIFO full, error and reset.
module tb_qracc_sram_arbiter;

    localparam int AW = 7;
    localparam int NC = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          r0_valid_i, r0_wr_i, r0_ready_o, r0_rd_valid_o;
    logic [AW-1:0] r0_addr_i;
    logic [NC-1:0] r0_wdata_i, r0_rd_data_o;
    logic          r1_valid_i, r1_wr_i, r1_ready_o, r1_rd_valid_o;
    logic [AW-1:0] r1_addr_i;
    logic [NC-1:0] r1_wdata_i, r1_rd_data_o;
    logic          rq_valid_o, rq_wr_o, rq_ready_i, rd_valid_i, err_o;
    logic [AW-1:0] addr_o;
    logic [NC-1:0] wr_data_o, rd_data_i;
`ifdef QRACC_SRAM_ARB_STATS_EN
    logic [31:0]   r0_grants_o, r1_grants_o, stall_cycles_o;
`endif

    int errors = 0;
    int checks = 0;
    int n0, n1;

    always #5 clk = ~clk;

    qracc_sram_arbiter dut (
        .clk           (clk),
        .nrst          (nrst),
        .r0_valid_i    (r0_valid_i),
        .r0_wr_i       (r0_wr_i),
        .r0_addr_i     (r0_addr_i),
        .r0_wdata_i    (r0_wdata_i),
        .r0_ready_o    (r0_ready_o),
        .r0_rd_valid_o (r0_rd_valid_o),
        .r0_rd_data_o  (r0_rd_data_o),
        .r1_valid_i    (r1_valid_i),
        .r1_wr_i       (r1_wr_i),
        .r1_addr_i     (r1_addr_i),
        .r1_wdata_i    (r1_wdata_i),
        .r1_ready_o    (r1_ready_o),
        .r1_rd_valid_o (r1_rd_valid_o),
        .r1_rd_data_o  (r1_rd_data_o),
        .rq_valid_o    (rq_valid_o),
        .rq_wr_o       (rq_wr_o),
        .addr_o        (addr_o),
        .wr_data_o     (wr_data_o),
        .rq_ready_i    (rq_ready_i),
        .rd_valid_i    (rd_valid_i),
        .rd_data_i     (rd_data_i),
`ifdef QRACC_SRAM_ARB_STATS_EN
        .r0_grants_o   (r0_grants_o),
        .r1_grants_o   (r1_grants_o),
        .stall_cycles_o(stall_cycles_o),
`endif
        .err_o         (err_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input logic v, input logic wr,
                          input logic [AW-1:0] a, input logic [NC-1:0] d);
        r0_valid_i = v; r0_wr_i = wr; r0_addr_i = a; r0_wdata_i = d;
    endtask

    task automatic set_r1(input logic v, input logic wr,
                          input logic [AW-1:0] a, input logic [NC-1:0] d);
        r1_valid_i = v; r1_wr_i = wr; r1_addr_i = a; r1_wdata_i = d;
    endtask

    task automatic ret(input logic v, input logic [NC-1:0] d);
        rd_valid_i = v; rd_data_i = d;
    endtask

    initial begin
        nrst = 1'b0;
        set_r0(0, 0, '0, '0);
        set_r1(0, 0, '0, '0);
        rq_ready_i = 1'b0;
        ret(0, '0);
        #12;
        check("rst_rq_valid", rq_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata0", r0_rd_data_o, 0);
        nrst = 1'b1;
        tick();

        // Round robin: both write continuously
        set_r0(1, 1, 7'h01, 32'h11);
        set_r1(1, 1, 7'h02, 32'h22);
        rq_ready_i = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            check($sformatf("rr_r0_rdy%0d", i), r0_ready_o, (i % 2) == 0);
            check($sformatf("rr_r1_rdy%0d", i), r1_ready_o, (i % 2) == 1);
            check($sformatf("rr_addr%0d", i), addr_o, (i % 2) ? 2 : 1);
            n0 += int'(r0_ready_o);
            n1 += int'(r1_ready_o);
            tick();
        end
        check("rr_n0", n0, 4);
        check("rr_n1", n1, 4);
        set_r0(0, 0, '0, '0);
        set_r1(0, 0, '0, '0);
        rq_ready_i = 1'b0;
        tick();

        // Stall hold: r1 granted, r0 arrives while held
        set_r1(1, 1, 7'h05, 32'hDEADBEEF);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_r0(1, 1, 7'h01, 32'h99);
            rq_ready_i = (c == 3);
            #2;
            check($sformatf("st_addr%0d", c), addr_o, 5);
            check($sformatf("st_wd%0d", c), wr_data_o, 32'hDEADBEEF);
            check($sformatf("st_r1rdy%0d", c), r1_ready_o, c == 3);
            check($sformatf("st_r0rdy%0d", c), r0_ready_o, 0);
            tick();
        end
        set_r1(0, 0, '0, '0);
        #2;
        check("st_r0_after", r0_ready_o, 1);
        tick();
        set_r0(0, 0, '0, '0);

        // In-order return
        set_r0(1, 0, 7'h10, '0);
        #2; check("io_acc0", r0_ready_o, 1); tick();
        set_r0(0, 0, '0, '0);
        set_r1(1, 0, 7'h20, '0);
        #2; check("io_acc1", r1_ready_o, 1); tick();
        set_r1(0, 0, '0, '0);
        set_r0(1, 0, 7'h30, '0);
        #2; check("io_acc2", r0_ready_o, 1); tick();
        set_r0(0, 0, '0, '0);
        rq_ready_i = 1'b0;
        ret(1, 32'hA);
        #2;
        check("io_v0a", r0_rd_valid_o, 1);
        check("io_v1a", r1_rd_valid_o, 0);
        check("io_da", r0_rd_data_o, 32'hA);
        tick();
        ret(1, 32'hB);
        #2;
        check("io_v0b", r0_rd_valid_o, 0);
        check("io_v1b", r1_rd_valid_o, 1);
        check("io_db", r1_rd_data_o, 32'hB);
        tick();
        ret(1, 32'hC);
        #2;
        check("io_v0c", r0_rd_valid_o, 1);
        check("io_v1c", r1_rd_valid_o, 0);
        check("io_dc", r0_rd_data_o, 32'hC);
        tick();
        ret(0, 32'h77);
        #2;
        check("io_hold_v", r0_rd_valid_o, 0);
        check("io_hold_d", r0_rd_data_o, 32'hC);
        check("io_no_err", err_o, 0);

        // FIFO full
        rq_ready_i = 1'b1;
        set_r0(1, 0, 7'h40, '0);
        for (int i = 0; i < 4; i++) begin
            #2; check($sformatf("ff_fill%0d", i), r0_ready_o, 1); tick();
        end
        set_r1(1, 1, 7'h41, 32'h55);
        #2;
        check("ff_r1_wr", r1_ready_o, 1);
        check("ff_r0_blk", r0_ready_o, 0);
        check("ff_wr", rq_wr_o, 1);
        tick();
        set_r1(0, 0, '0, '0);
        #2; check("ff_blocked", rq_valid_o, 0); tick();
        ret(1, 32'h1);
        #2;
        check("ff_pop_v", r0_rd_valid_o, 1);
        check("ff_pop_nogrant", rq_valid_o, 0);
        tick();
        ret(0, '0);
        #2; check("ff_reacc", r0_ready_o, 1); tick();
        ret(1, 32'h2);
        #2; check("ff_pop2_blk", rq_valid_o, 0); tick();
        ret(1, 32'h3);
        #2;
        check("pp_push", r0_ready_o, 1);
        check("pp_pop", r0_rd_valid_o, 1);
        check("pp_data", r0_rd_data_o, 32'h3);
        tick();
        ret(0, '0);
        #2; check("pp_fill", r0_ready_o, 1); tick();
        #2; check("pp_full", rq_valid_o, 0); tick();
        set_r0(0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            ret(1, 32'h100 + i);
            #2;
            check($sformatf("dr_v%0d", i), r0_rd_valid_o, 1);
            check($sformatf("dr_d%0d", i), r0_rd_data_o, 32'h100 + i);
            tick();
        end

        // Error on empty return
        ret(1, 32'hEE);
        #2;
        check("er_v0", r0_rd_valid_o, 0);
        check("er_v1", r1_rd_valid_o, 0);
        check("er_pre", err_o, 0);
        tick();
        ret(0, '0);
        #2; check("er_set", err_o, 1);
        tick();
        #2; check("er_sticky", err_o, 1);

        // Reset while holding a stalled request
        rq_ready_i = 1'b0;
        set_r1(1, 1, 7'h33, 32'h1234);
        tick();
        #2; check("rh_hold", rq_valid_o, 1);
        nrst = 1'b0;
        #1;
        check("rh_rqv", rq_valid_o, 0);
        check("rh_addr", addr_o, 0);
        check("rh_wd", wr_data_o, 0);
        check("rh_err", err_o, 0);
        check("rh_rd0", r0_rd_data_o, 0);
        set_r1(0, 0, '0, '0);
        tick();
        nrst = 1'b1;
        tick();
        ret(1, 32'h5);
        #2; check("rh_empty", r0_rd_valid_o | r1_rd_valid_o, 0);
        tick();
        ret(0, '0);

`ifdef QRACC_SRAM_ARB_STATS_EN
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        rq_ready_i = 1'b1;
        set_r0(1, 1, 7'h01, 32'h1);
        repeat (6) tick();
        set_r0(0, 0, '0, '0);
        set_r1(1, 1, 7'h02, 32'h2);
        rq_ready_i = 1'b0;
        repeat (5) tick();
        rq_ready_i = 1'b1;
        repeat (2) tick();
        set_r1(0, 0, '0, '0);
        tick();
        check("sx_r0", r0_grants_o, 6);
        check("sx_r1", r1_grants_o, 2);
        check("sx_stall", stall_cycles_o, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
